// File: rtl/controlador_forno_pkg.sv
// Shared types and default constants for the microwave oven timer controller.
// The optional done alarm is enabled by defining CONTROLADOR_FORNO_ALARME_EN.
package controlador_forno_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int TEMPO_W          = 7;
   localparam int DEF_INC_SEC      = 15;
   localparam int DEF_MAX_ADDS     = 4;
   localparam int DEF_MAX_TIME     = 99;
   localparam int DEF_ALARM_CYCLES = 8;

endpackage

// File: rtl/detector_borda.sv
// Registered rising-edge detector for an already debounced button level.
// The first cycle after reset only records the level, so a held button never fires.
module detector_borda (
   input  logic CK,
   input  logic reset_n,
   input  logic sinal,
   output logic borda
);

   logic prev_q, prev_d;
   logic armado_q, armado_d;

   always_comb begin
      prev_d   = sinal;
      armado_d = 1'b1;
   end

   // NOTE: reset is sampled on the clock edge; flops use non-blocking assignments only.
   always_ff @(posedge CK) begin
      if (!reset_n) begin
         prev_q   <= 1'b0;
         armado_q <= 1'b0;
      end else begin
         prev_q   <= prev_d;
         armado_q <= armado_d;
      end
   end

   assign borda = sinal & ~prev_q & armado_q;

endmodule

// File: rtl/controlador_forno.sv
// Microwave oven countdown controller: start/add buttons, lid pause, 1 Hz countdown.
// Define CONTROLADOR_FORNO_ALARME_EN to add the alarme output and a multi-cycle DONE.
module controlador_forno
   import controlador_forno_pkg::*;
#(
   parameter int INC_SEC      = DEF_INC_SEC,
   parameter int MAX_ADDS     = DEF_MAX_ADDS,
   parameter int MAX_TIME     = DEF_MAX_TIME,
   parameter int ALARM_CYCLES = DEF_ALARM_CYCLES
) (
   input  logic               CK,
   input  logic               reset_n,
   input  logic               ini,
   input  logic               adicionar,
   input  logic               tampa,
   input  logic               tick_1s,
   output logic [TEMPO_W-1:0] tempo,
   output logic               TemR,
   output logic [1:0]         estado
`ifdef CONTROLADOR_FORNO_ALARME_EN
   ,
   output logic               alarme
`endif
);

   localparam int ADDS_W = $clog2(MAX_ADDS + 1);

   if (INC_SEC < 1 || INC_SEC > MAX_TIME || MAX_TIME > (2 ** TEMPO_W) - 1 ||
       MAX_ADDS < 1 || ALARM_CYCLES < 1) begin : g_param_err
      $error("controlador_forno: parameter set out of range");
   end

   logic ini_borda;
   logic adic_borda;

   detector_borda u_borda_ini (
      .CK      (CK),
      .reset_n (reset_n),
      .sinal   (ini),
      .borda   (ini_borda)
   );

   detector_borda u_borda_adic (
      .CK      (CK),
      .reset_n (reset_n),
      .sinal   (adicionar),
      .borda   (adic_borda)
   );

   state_t               estado_q, estado_d;
   logic [TEMPO_W-1:0]   tempo_q, tempo_d;
   logic [ADDS_W-1:0]    adds_left_q, adds_left_d;
   int                   tempo_calc;
   logic                 add_ok;

`ifdef CONTROLADOR_FORNO_ALARME_EN
   localparam int ALARM_W = $clog2(ALARM_CYCLES + 1);
   logic [ALARM_W-1:0]   alarm_cnt_q, alarm_cnt_d;
`endif

   // NOTE: every signal gets a default first so no path can infer a latch.
   always_comb begin
      estado_d    = estado_q;
      tempo_d     = tempo_q;
      adds_left_d = adds_left_q;
      tempo_calc  = int'(tempo_q);
      add_ok      = 1'b0;
`ifdef CONTROLADOR_FORNO_ALARME_EN
      alarm_cnt_d = alarm_cnt_q;
`endif

      unique case (estado_q)
         ST_IDLE: begin
            if (ini_borda && !tampa) begin
               tempo_d     = TEMPO_W'(INC_SEC);
               adds_left_d = ADDS_W'(MAX_ADDS - 1);
               estado_d    = ST_RUN;
            end
         end

         ST_RUN: begin
            // Opening the lid freezes everything else that happens in this cycle.
            if (tampa) begin
               estado_d = ST_PAUSE;
            end else begin
               add_ok = adic_borda && (adds_left_q != '0);
               if (tick_1s) begin
                  tempo_calc = tempo_calc - 1;
               end
               if (add_ok) begin
                  tempo_calc  = tempo_calc + INC_SEC;
                  adds_left_d = adds_left_q - ADDS_W'(1);
               end
               if (tempo_calc > MAX_TIME) begin
                  tempo_calc = MAX_TIME;
               end
               tempo_d = TEMPO_W'(tempo_calc);
               if (tempo_calc == 0) begin
                  estado_d = ST_DONE;
               end
            end
         end

         ST_PAUSE: begin
            if (!tampa) begin
               estado_d = ST_RUN;
            end
         end

         ST_DONE: begin
            tempo_d = '0;
`ifdef CONTROLADOR_FORNO_ALARME_EN
            if (alarm_cnt_q == ALARM_W'(ALARM_CYCLES - 1)) begin
               alarm_cnt_d = '0;
               estado_d    = ST_IDLE;
            end else begin
               alarm_cnt_d = alarm_cnt_q + ALARM_W'(1);
            end
`else
            estado_d = ST_IDLE;
`endif
         end

         default: estado_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CK) begin
      if (!reset_n) begin
         estado_q    <= ST_IDLE;
         tempo_q     <= '0;
         adds_left_q <= '0;
`ifdef CONTROLADOR_FORNO_ALARME_EN
         alarm_cnt_q <= '0;
`endif
      end else begin
         estado_q    <= estado_d;
         tempo_q     <= tempo_d;
         adds_left_q <= adds_left_d;
`ifdef CONTROLADOR_FORNO_ALARME_EN
         alarm_cnt_q <= alarm_cnt_d;
`endif
      end
   end

   assign tempo  = tempo_q;
   assign TemR   = (tempo_q != '0);
   assign estado = estado_q;
`ifdef CONTROLADOR_FORNO_ALARME_EN
   assign alarme = (estado_q == ST_DONE);
`endif

endmodule

// File: tb/tb_controlador_forno.sv
// Self-checking bench: two controller instances (default and MAX_ADDS=8/ALARM_CYCLES=3)
// driven by shared directed and random stimulus, compared every cycle to a behavioural model.
module tb_controlador_forno;

   logic       CK = 1'b0;
   logic       reset_n;
   logic       ini;
   logic       adicionar;
   logic       tampa;
   logic       tick_1s;
   logic [6:0] tempo_a, tempo_b;
   logic       temr_a, temr_b;
   logic [1:0] estado_a, estado_b;
`ifdef CONTROLADOR_FORNO_ALARME_EN
   logic       alarme_a, alarme_b;
   localparam int DONE_A = 8;
   localparam int DONE_B = 3;
`else
   localparam int DONE_A = 1;
   localparam int DONE_B = 1;
`endif

   int total = 0;
   int bad   = 0;

   always #5 CK = ~CK;

   controlador_forno dut_a (
      .CK        (CK),
      .reset_n   (reset_n),
      .ini       (ini),
      .adicionar (adicionar),
      .tampa     (tampa),
      .tick_1s   (tick_1s),
      .tempo     (tempo_a),
      .TemR      (temr_a),
      .estado    (estado_a)
`ifdef CONTROLADOR_FORNO_ALARME_EN
      ,
      .alarme    (alarme_a)
`endif
   );

   controlador_forno #(
      .INC_SEC      (15),
      .MAX_ADDS     (8),
      .MAX_TIME     (99),
      .ALARM_CYCLES (3)
   ) dut_b (
      .CK        (CK),
      .reset_n   (reset_n),
      .ini       (ini),
      .adicionar (adicionar),
      .tampa     (tampa),
      .tick_1s   (tick_1s),
      .tempo     (tempo_b),
      .TemR      (temr_b),
      .estado    (estado_b)
`ifdef CONTROLADOR_FORNO_ALARME_EN
      ,
      .alarme    (alarme_b)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int phase;      // 0 idle, 1 running, 2 paused, 3 done
      int t;          // remaining seconds
      int adds;       // load/add events still allowed
      int done_left;  // cycles of DONE still to go
   } mdl_t;

   mdl_t ma, mb;
   bit   prev_ini, prev_add, armed;

   function automatic mdl_t mdl_next(mdl_t m, bit rst, bit ie, bit ae, bit lid, bit tk,
                                     int inc, int max_adds, int max_t, int done_len);
      mdl_t n;
      bit   add_ok;
      n = m;
      if (rst) begin
         n.phase = 0; n.t = 0; n.adds = 0; n.done_left = 0;
         return n;
      end
      case (m.phase)
         0: if (ie && !lid) begin
               n.t = inc; n.adds = max_adds - 1; n.phase = 1;
            end
         1: if (lid) begin
               n.phase = 2;
            end else begin
               add_ok = ae && (m.adds > 0);
               n.t = m.t - (tk ? 1 : 0) + (add_ok ? inc : 0);
               if (n.t > max_t) n.t = max_t;
               if (add_ok) n.adds = m.adds - 1;
               if (n.t == 0) begin
                  n.phase = 3; n.done_left = done_len;
               end
            end
         2: if (!lid) n.phase = 1;
         default: begin
            n.t = 0;
            n.done_left = m.done_left - 1;
            if (n.done_left == 0) n.phase = 0;
         end
      endcase
      return n;
   endfunction

   // Model advances on each rising edge from the sampled inputs; outputs checked 1 ns later.
   always @(posedge CK) begin
      bit ie, ae, rst;
      rst = !reset_n;
      ie  = ini && !prev_ini && armed;
      ae  = adicionar && !prev_add && armed;
      if (rst) begin
         prev_ini = 0; prev_add = 0; armed = 0;
      end else begin
         prev_ini = ini; prev_add = adicionar; armed = 1;
      end
      ma = mdl_next(ma, rst, ie, ae, tampa, tick_1s, 15, 4, 99, DONE_A);
      mb = mdl_next(mb, rst, ie, ae, tampa, tick_1s, 15, 8, 99, DONE_B);
      #1;
      check("a_estado", estado_a, ma.phase);
      check("a_tempo",  tempo_a,  ma.t);
      check("a_temr",   temr_a,   (ma.t != 0));
      check("b_estado", estado_b, mb.phase);
      check("b_tempo",  tempo_b,  mb.t);
      check("b_temr",   temr_b,   (mb.t != 0));
`ifdef CONTROLADOR_FORNO_ALARME_EN
      check("a_alarme", alarme_a, (ma.phase == 3));
      check("b_alarme", alarme_b, (mb.phase == 3));
`endif
   end

   // Drive one cycle of inputs at the falling edge and return at the next falling edge.
   task automatic step(input bit i, input bit a, input bit l, input bit k);
      ini = i; adicionar = a; tampa = l; tick_1s = k;
      @(negedge CK);
   endtask

   initial begin
      int exp34[4];
      bit r_tampa;
      exp34 = '{30, 45, 60, 60};
      ini = 0; adicionar = 0; tampa = 0; tick_1s = 0; reset_n = 0;
      repeat (2) @(negedge CK);
      check("rst_estado", estado_a, 0);
      check("rst_tempo",  tempo_a,  0);
      check("rst_temr",   temr_a,   0);
      reset_n = 1;
      step(0, 0, 0, 0);

      // start then a full 15 s countdown
      step(1, 0, 0, 0);
      check("start_tempo",  tempo_a,  15);
      check("start_estado", estado_a, 1);
      step(0, 0, 0, 0);
      for (int i = 1; i <= 15; i++) begin
         step(0, 0, 0, 1);
         check("count_tempo", tempo_a, 15 - i);
         check("count_estado", estado_a, (i < 15) ? 1 : 3);
      end
      check("done_temr", temr_a, 0);
`ifdef CONTROLADOR_FORNO_ALARME_EN
      check("alarm_first", alarme_a, 1);
      for (int j = 0; j < 7; j++) begin
         step(0, 0, 0, 0);
         check("alarm_estado", estado_a, 3);
         check("alarm_on", alarme_a, 1);
      end
      step(0, 0, 0, 0);
      check("alarm_off", alarme_a, 0);
      check("alarm_idle", estado_a, 0);
`else
      step(0, 0, 0, 0);
      check("done_to_idle", estado_a, 0);
`endif
      repeat (3) step(0, 0, 0, 0);

      // start plus four add presses; the fourth exceeds the event budget
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         step(0, 1, 0, 0);
         check("add_tempo", tempo_a, exp34[k]);
         step(0, 0, 0, 0);
      end

      // count down to 40, ini is ignored while running, then reset with ini held
      repeat (20) step(0, 0, 0, 1);
      check("at40_tempo", tempo_a, 40);
      step(1, 0, 0, 0);
      check("run_ini_ign", estado_a, 1);
      check("run_ini_tmp", tempo_a, 40);
      reset_n = 0;
      step(1, 0, 0, 1);
      check("midrun_rst_estado", estado_a, 0);
      check("midrun_rst_tempo",  tempo_a,  0);
      reset_n = 1;
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      check("held_ini_estado", estado_a, 0);
      check("held_ini_tempo",  tempo_a,  0);
      step(0, 0, 0, 0);

      // saturation at 99 and tick+add at tempo 1 (instance with 8 events)
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      for (int k = 1; k <= 6; k++) begin
         step(0, 1, 0, 0);
         if (k == 5) check("b_at90", tempo_b, 90);
         if (k == 6) check("b_sat99", tempo_b, 99);
         step(0, 0, 0, 0);
      end
      repeat (98) step(0, 0, 0, 1);
      check("b_at1", tempo_b, 1);
      step(0, 1, 0, 1);
      check("b_tick_add_tempo",  tempo_b,  15);
      check("b_tick_add_estado", estado_b, 1);
      reset_n = 0;
      step(0, 0, 0, 0);
      reset_n = 1;
      step(0, 0, 0, 0);

      // lid opened together with a tick at tempo 10
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      repeat (5) step(0, 0, 0, 1);
      check("at10_tempo", tempo_a, 10);
      step(0, 0, 1, 1);
      check("pause_estado", estado_a, 2);
      check("pause_tempo",  tempo_a,  10);
      step(0, 0, 1, 1);
      step(0, 1, 1, 0);
      step(1, 0, 1, 0);
      step(0, 0, 1, 0);
      check("pause_hold_estado", estado_a, 2);
      check("pause_hold_tempo",  tempo_a,  10);
      step(0, 0, 0, 0);
      check("resume_estado", estado_a, 1);
      check("resume_tempo",  tempo_a,  10);
      step(0, 0, 0, 1);
      check("resume_tick", tempo_a, 9);

      // random traffic, every cycle checked by the model process
      r_tampa = 0;
      for (int c = 0; c < 4000; c++) begin
         reset_n = ($urandom_range(0, 199) != 0);
         if ($urandom_range(0, 11) == 0) r_tampa = ~r_tampa;
         step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, r_tampa,
              $urandom_range(0, 1) == 0);
      end
      reset_n = 1;
      repeat (3) step(0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/controlador_forno.md
CONTROLADOR_FORNO -- requirements
Module: controlador_forno

Interface
REQ-001 SHALL have parameter INC_SEC, default 15, seconds loaded on start and added per accepted add press.
REQ-002 SHALL have parameter MAX_ADDS, default 4, total accepted load/add events per cycle, including the start.
REQ-003 SHALL have parameter MAX_TIME, default 99, saturation ceiling of the remaining time.
REQ-004 SHALL have parameter ALARM_CYCLES, default 8, length of the done alarm in clocks.
REQ-005 SHALL have port CK  in  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port ini  in  1  start button level, already debounced.
REQ-008 SHALL have port adicionar  in  1  add-time button level, already debounced.
REQ-009 SHALL have port tampa  in  1  lid open when 1.
REQ-010 SHALL have port tick_1s  in  1  one-cycle 1 Hz enable strobe.
REQ-011 SHALL have port tempo  out  7  remaining seconds, binary, 0..MAX_TIME.
REQ-012 SHALL have port TemR  out  1  high when tempo != 0.
REQ-013 SHALL have port estado  out  2  current FSM state code.
REQ-014 SHALL have port alarme  out  1  done alarm (present only with the macro, REQ-030).

Function
REQ-015 SHALL detect rising edges of ini and adicionar with a registered previous value; an edge acts on the first rising CK edge after it is sampled; held levels SHALL NOT retrigger.
REQ-016 SHALL implement states IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-017 In IDLE: an ini edge with tampa=0 SHALL set tempo=INC_SEC and adds_left=MAX_ADDS-1, then enter RUN; an ini edge with tampa=1 SHALL be ignored.
REQ-018 In RUN: tick_1s SHALL decrement tempo by 1; an adicionar edge with adds_left>0 SHALL add INC_SEC, saturate at MAX_TIME, and decrement adds_left; with adds_left=0 it SHALL be ignored.
REQ-019 In RUN: if tick and add occur in the same cycle, tempo SHALL become min(tempo-1+INC_SEC, MAX_TIME).
REQ-020 In RUN: when the next tempo equals 0, the FSM SHALL enter DONE in the same update.
REQ-021 In RUN: tampa=1 SHALL enter PAUSE with tempo held; this SHALL override tick and add in that cycle.
REQ-022 In PAUSE: tempo SHALL be held and ini, adicionar and tick SHALL be ignored; tampa=0 SHALL return to RUN.
REQ-023 In RUN: an ini edge SHALL be ignored.
REQ-024 In DONE: tempo SHALL be 0 and all inputs SHALL be ignored; the FSM SHALL return to IDLE after 1 cycle (after ALARM_CYCLES cycles with the macro).
REQ-025 TemR SHALL be combinational from tempo; estado SHALL be the state register.

Reset
REQ-026 reset_n=0 at a CK edge SHALL force IDLE, tempo=0, adds_left=0, edge registers=0, alarm counter=0 and alarme=0, overriding every event in that cycle, including mid-RUN and mid-PAUSE.
REQ-027 After reset release, a button already held SHALL NOT produce an edge.

Configuration
REQ-028 Macro CONTROLADOR_FORNO_ALARME_EN SHALL gate the alarm feature.
REQ-029 Without the macro: the alarme port and alarm counter SHALL be absent, and DONE SHALL last 1 cycle.
REQ-030 With the macro: alarme SHALL be 1 for exactly ALARM_CYCLES cycles from DONE entry, then DONE->IDLE.

Structure
REQ-031 Package controlador_forno_pkg SHALL hold the state enum, the state codes and the default constants INC_SEC, MAX_ADDS, MAX_TIME and ALARM_CYCLES.
REQ-032 Sub-module detector_borda (registered rising-edge detector) SHALL be instantiated once per button.

Verification
REQ-033 ini edge, then 15 ticks -> tempo 15,14..0; DONE on the 15th tick; TemR falls; IDLE next cycle (no macro).
REQ-034 Start, then 4 adicionar edges -> tempo 30, 45, 60; the 4th add is ignored; tempo=60.
REQ-035 tempo=90 plus an add -> tempo=99; tick and add together at tempo=1 -> tempo=15, state stays RUN.
REQ-036 tampa=1 with a tick in the same cycle at tempo=10 -> PAUSE, tempo=10; ticks and adds ignored; tampa=0 -> RUN, next tick gives 9.
REQ-037 reset_n=0 mid-RUN at tempo=40 with ini held -> next cycle IDLE, tempo=0; release with ini still high -> no start.
REQ-038 With macro: countdown ends -> alarme high for exactly 8 cycles, estado=3, then IDLE with alarme=0.
